// File: rtl/fetch2_pkg.sv
// Shared constants and the fetch-queue entry layout for the second fetch stage.
package fetch2_pkg;

    localparam logic [31:0] NOP_INST   = 32'h00000013;
    localparam int          FQ_ENTRY_W = 65;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } fq_entry_t;

endpackage

// File: rtl/fetch2_inst_queue.sv
// Two-write/two-read circular instruction buffer; head two entries are read combinationally.
module inst_queue
    import fetch2_pkg::*;
#(
    parameter int DEPTH = 8,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  clear,
    input  logic [1:0]            enq_cnt,
    input  logic [FQ_ENTRY_W-1:0] enq0,
    input  logic [FQ_ENTRY_W-1:0] enq1,
    input  logic [1:0]            deq_cnt,
    output logic [FQ_ENTRY_W-1:0] head0,
    output logic [FQ_ENTRY_W-1:0] head1,
    output logic [CW-1:0]         count
);

    logic [FQ_ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;

    // Storage needs no reset: count gates every read out of the queue.
    always_ff @(posedge clock_i) begin
        if (!clear) begin
            if (enq_cnt != 2'd0) mem[wr_ptr] <= enq0;
            if (enq_cnt == 2'd2) mem[wr_ptr + AW'(1)] <= enq1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + AW'(enq_cnt);
            rd_ptr <= rd_ptr + AW'(deq_cnt);
            count  <= count + CW'(enq_cnt) - CW'(deq_cnt);
        end
    end

    assign head0 = mem[rd_ptr];
    assign head1 = mem[rd_ptr + AW'(1)];

endmodule

// File: rtl/fetch2.sv
// Second fetch stage: splits a 64-bit fetch word into tagged instructions,
// queues them in order and presents a dual-issue pair to decode.
module fetch2
    import fetch2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clock_i,
    input  logic        reset_n_i,
    input  logic        fetch_valid_i,
    input  logic [31:0] fetch_pc_i,
    input  logic [63:0] imem_data_i,
    input  logic        pred_taken_0_i,
    input  logic        pred_taken_1_i,
    input  logic        flush_i,
    input  logic        ready_i,
    output logic        pc_we_o,
    output logic        valid0_o,
    output logic        valid1_o,
    output logic [31:0] inst0_o,
    output logic [31:0] inst1_o,
    output logic [31:0] pc0_o,
    output logic [31:0] pc1_o,
    output logic        pred0_o,
    output logic        pred1_o
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic      drop_q, drop;
    logic [1:0] enq_cnt, deq_cnt;
    fq_entry_t enq0, enq1, head0, head1;
    logic [CW-1:0] count;

    // The fetch in the cycle after a flush is the stale return from the old PC.
    assign drop = flush_i || drop_q;

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) drop_q <= 1'b0;
        else            drop_q <= flush_i;
    end

    always_comb begin
        enq_cnt = 2'd0;
        enq0    = '0;
        enq1    = '0;
        if (fetch_valid_i && !drop) begin
            if (fetch_pc_i[2]) begin
                enq_cnt = 2'd1;
                enq0    = '{pc: fetch_pc_i, inst: imem_data_i[63:32], pred: pred_taken_1_i};
            end else if (pred_taken_0_i) begin
                // Upper word is past a predicted-taken branch: wrong path.
                enq_cnt = 2'd1;
                enq0    = '{pc: fetch_pc_i, inst: imem_data_i[31:0], pred: 1'b1};
            end else begin
                enq_cnt = 2'd2;
                enq0    = '{pc: fetch_pc_i, inst: imem_data_i[31:0], pred: 1'b0};
                enq1    = '{pc: fetch_pc_i + 32'd4, inst: imem_data_i[63:32], pred: pred_taken_1_i};
            end
        end
    end

    assign valid0_o = (count != '0);
    assign valid1_o = (count >= CW'(2));
    assign deq_cnt  = (ready_i && !flush_i) ? {1'b0, valid0_o} + {1'b0, valid1_o} : 2'd0;

    // Four free slots absorb the fetch in flight plus the one about to issue.
    assign pc_we_o = (count <= CW'(DEPTH - 4)) && !flush_i;

    inst_queue #(.DEPTH(DEPTH)) u_queue (
        .clock_i   (clock_i),
        .reset_n_i (reset_n_i),
        .clear     (flush_i),
        .enq_cnt   (enq_cnt),
        .enq0      (enq0),
        .enq1      (enq1),
        .deq_cnt   (deq_cnt),
        .head0     (head0),
        .head1     (head1),
        .count     (count)
    );

    assign inst0_o = valid0_o ? head0.inst : NOP_INST;
    assign pc0_o   = valid0_o ? head0.pc   : 32'd0;
    assign pred0_o = valid0_o && head0.pred;
    assign inst1_o = valid1_o ? head1.inst : NOP_INST;
    assign pc1_o   = valid1_o ? head1.pc   : 32'd0;
    assign pred1_o = valid1_o && head1.pred;

endmodule

// File: tb/tb_fetch2.sv
// Directed and randomized checks of fetch2 against a queue-based reference model.
module tb_fetch2;
    localparam int DEPTH = 8;
    localparam logic [31:0] NOP = 32'h00000013;

    logic clock_i = 1'b0;
    logic reset_n_i, fetch_valid_i, pred_taken_0_i, pred_taken_1_i, flush_i, ready_i;
    logic [31:0] fetch_pc_i;
    logic [63:0] imem_data_i;
    logic pc_we_o, valid0_o, valid1_o, pred0_o, pred1_o;
    logic [31:0] inst0_o, inst1_o, pc0_o, pc1_o;

    always #5 clock_i = ~clock_i;

    fetch2 #(.DEPTH(DEPTH)) dut (
        .clock_i(clock_i), .reset_n_i(reset_n_i), .fetch_valid_i(fetch_valid_i),
        .fetch_pc_i(fetch_pc_i), .imem_data_i(imem_data_i),
        .pred_taken_0_i(pred_taken_0_i), .pred_taken_1_i(pred_taken_1_i),
        .flush_i(flush_i), .ready_i(ready_i), .pc_we_o(pc_we_o),
        .valid0_o(valid0_o), .valid1_o(valid1_o), .inst0_o(inst0_o), .inst1_o(inst1_o),
        .pc0_o(pc0_o), .pc1_o(pc1_o), .pred0_o(pred0_o), .pred1_o(pred1_o)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred;
    } ent_t;

    ent_t mq[$];
    bit   m_drop;
    bit   prev_we;
    int   n_vec, n_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_we();
        return (DEPTH - mq.size() >= 4) && !flush_i;
    endfunction

    task automatic check_outputs();
        bit v0, v1;
        v0 = mq.size() >= 1;
        v1 = mq.size() >= 2;
        chk("valid0", 32'(valid0_o), 32'(v0));
        chk("valid1", 32'(valid1_o), 32'(v1));
        chk("inst0", inst0_o, v0 ? mq[0].inst : NOP);
        chk("pc0", pc0_o, v0 ? mq[0].pc : 32'd0);
        chk("pred0", 32'(pred0_o), v0 ? 32'(mq[0].pred) : 32'd0);
        chk("inst1", inst1_o, v1 ? mq[1].inst : NOP);
        chk("pc1", pc1_o, v1 ? mq[1].pc : 32'd0);
        chk("pred1", 32'(pred1_o), v1 ? 32'(mq[1].pred) : 32'd0);
        chk("pc_we", 32'(pc_we_o), 32'(exp_we()));
    endtask

    // One clock: check at the falling edge, advance the model, return just after the rising edge.
    task automatic step();
        int n;
        @(negedge clock_i);
        check_outputs();
        prev_we = exp_we();
        if (flush_i) begin
            mq.delete();
            m_drop = 1'b1;
        end else begin
            if (ready_i) begin
                n = (mq.size() >= 2) ? 2 : mq.size();
                repeat (n) void'(mq.pop_front());
            end
            if (fetch_valid_i && !m_drop) begin
                if (fetch_pc_i[2])
                    mq.push_back('{fetch_pc_i, imem_data_i[63:32], pred_taken_1_i});
                else if (pred_taken_0_i)
                    mq.push_back('{fetch_pc_i, imem_data_i[31:0], 1'b1});
                else begin
                    mq.push_back('{fetch_pc_i, imem_data_i[31:0], 1'b0});
                    mq.push_back('{fetch_pc_i + 32'd4, imem_data_i[63:32], pred_taken_1_i});
                end
            end
            m_drop = 1'b0;
            chk("no_overflow", 32'(mq.size() <= DEPTH), 32'd1);
        end
        @(posedge clock_i);
        #1;
    endtask

    task automatic fetch(input logic v, input logic [31:0] pc, input logic [63:0] d,
                         input logic p0, input logic p1);
        fetch_valid_i  = v;
        fetch_pc_i     = pc;
        imem_data_i    = d;
        pred_taken_0_i = p0;
        pred_taken_1_i = p1;
    endtask

    function automatic logic [63:0] seq_data(input logic [31:0] pc);
        return {pc ^ 32'hA5A50000, pc ^ 32'h5A5A0000};
    endfunction

    initial begin
        logic [31:0] pc, nxt;
        n_vec = 0; n_err = 0; m_drop = 0; prev_we = 1;
        reset_n_i = 1'b0; flush_i = 1'b0; ready_i = 1'b0;
        fetch(0, 32'd0, 64'd0, 0, 0);

        // Reset state
        repeat (2) @(posedge clock_i);
        #1;
        chk("rst_valid0", 32'(valid0_o), 32'd0);
        chk("rst_valid1", 32'(valid1_o), 32'd0);
        chk("rst_pc_we", 32'(pc_we_o), 32'd1);
        chk("rst_inst0", inst0_o, NOP);
        chk("rst_pc0", pc0_o, 32'd0);
        chk("rst_pred1", 32'(pred1_o), 32'd0);
        reset_n_i = 1'b1;
        step();

        // Aligned pair
        fetch(1, 32'h100, {32'h00500093, 32'h00400113}, 0, 0);
        step();
        fetch(0, 32'd0, 64'd0, 0, 0);
        chk("pair_inst0", inst0_o, 32'h00400113);
        chk("pair_pc0", pc0_o, 32'h100);
        chk("pair_inst1", inst1_o, 32'h00500093);
        chk("pair_pc1", pc1_o, 32'h104);
        chk("pair_valid1", 32'(valid1_o), 32'd1);
        ready_i = 1'b1;
        step();

        // Odd entry, then predicted-taken lower
        ready_i = 1'b0;
        fetch(1, 32'h104, {32'h11111111, 32'h22222222}, 0, 1);
        step();
        chk("odd_valid1", 32'(valid1_o), 32'd0);
        chk("odd_pc0", pc0_o, 32'h104);
        chk("odd_inst0", inst0_o, 32'h11111111);
        ready_i = 1'b1;
        fetch(1, 32'h100, {32'h33333333, 32'h44444444}, 1, 1);
        step();
        ready_i = 1'b0;
        fetch(0, 32'd0, 64'd0, 0, 0);
        chk("ptk_pc0", pc0_o, 32'h100);
        chk("ptk_pred0", 32'(pred0_o), 32'd1);
        chk("ptk_valid1", 32'(valid1_o), 32'd0);
        ready_i = 1'b1;
        step();

        // Back-pressure with continuous fetches gated by fetch1's PC enable
        ready_i = 1'b0;
        pc = 32'h2000;
        for (int i = 0; i < 8; i++) begin
            fetch(prev_we, pc, seq_data(pc), 0, 0);
            if (prev_we) pc += 8;
            step();
        end
        fetch(0, 32'd0, 64'd0, 0, 0);
        chk("bp_pc_we_low", 32'(pc_we_o), 32'd0);
        ready_i = 1'b1;
        repeat (5) step();

        // Flush with fetches in flight
        ready_i = 1'b0;
        fetch(1, 32'h300, seq_data(32'h300), 0, 0);
        step();
        flush_i = 1'b1;
        fetch(1, 32'h308, seq_data(32'h308), 0, 0);
        step();
        flush_i = 1'b0;
        chk("fl_empty", 32'(valid0_o), 32'd0);
        fetch(1, 32'h310, seq_data(32'h310), 0, 0);
        step();
        chk("fl_still_empty", 32'(valid0_o), 32'd0);
        fetch(1, 32'h400, seq_data(32'h400), 0, 0);
        step();
        fetch(0, 32'd0, 64'd0, 0, 0);
        chk("fl_first_pc", pc0_o, 32'h400);
        ready_i = 1'b1;
        step();

        // Pointer wrap with sequential PCs
        pc = 32'h8000; nxt = 32'h8000;
        for (int i = 0; i < 20; i++) begin
            ready_i = i[0];
            fetch(prev_we && !i[0], pc, seq_data(pc), 0, 0);
            if (prev_we && !i[0]) pc += 8;
            if (ready_i && valid0_o) begin
                chk("wrap_seq0", pc0_o, nxt);
                nxt += 4;
                if (valid1_o) begin
                    chk("wrap_seq1", pc1_o, nxt);
                    nxt += 4;
                end
            end
            step();
        end
        fetch(0, 32'd0, 64'd0, 0, 0);
        ready_i = 1'b1;
        repeat (4) step();

        // Async reset mid-operation at count 5
        ready_i = 1'b0;
        fetch(1, 32'h500, seq_data(32'h500), 0, 0); step();
        fetch(1, 32'h508, seq_data(32'h508), 0, 0); step();
        fetch(1, 32'h514, seq_data(32'h510), 0, 0); step();
        fetch(0, 32'd0, 64'd0, 0, 0);
        chk("pre_rst_count5", 32'(mq.size()), 32'd5);
        #1 reset_n_i = 1'b0;
        #1;
        chk("arst_valid0", 32'(valid0_o), 32'd0);
        chk("arst_valid1", 32'(valid1_o), 32'd0);
        chk("arst_pc_we", 32'(pc_we_o), 32'd1);
        chk("arst_inst0", inst0_o, NOP);
        mq.delete();
        m_drop = 1'b0;
        #1 reset_n_i = 1'b1;
        repeat (2) step();

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            flush_i = ($urandom_range(0, 15) == 0);
            ready_i = ($urandom_range(0, 2) != 0);
            pc = {$urandom_range(0, 32'h3FFF), 2'b00};
            fetch(prev_we && ($urandom_range(0, 3) != 0), pc,
                  {$urandom, $urandom}, 1'($urandom_range(0, 3) == 0), 1'($urandom));
            step();
        end
        flush_i = 1'b0;
        fetch(0, 32'd0, 64'd0, 0, 0);
        ready_i = 1'b1;
        repeat (5) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
